quantum_scheduler: RTL

Preemption timer and fetch-gating controller for the single-cycle processor. It counts retired cycles of the running process against a programmable quantum and raises a one-cycle `intSig` to the control unit when the quantum expires. It services the control unit's `stopQnt`/`rstQnt` strobes and freezes the PC while a `Halt` (input wait) is outstanding. It sits between the control unit's outputs and the PC register's enable.

---
 rtl/quantum_scheduler_if.sv | 26 ++
 rtl/quantum_scheduler.sv | 118 +++++++++++
 2 files changed

// File: rtl/quantum_scheduler_if.sv
// Control-unit <-> quantum scheduler signal bundle.
// master: control unit / input device side; slave: the scheduler.
interface quantum_scheduler_if #(
    parameter int QNT_WIDTH = 16
);
    logic                 stopQnt;
    logic                 rstQnt;
    logic                 halt;
    logic                 ioDone;
    logic                 qntLoad;
    logic [QNT_WIDTH-1:0] qntValue;
    logic                 intSig;
    logic                 pcEnable;
    logic                 running;
    logic [QNT_WIDTH-1:0] qntCount;

    modport master (
        output stopQnt, rstQnt, halt, ioDone, qntLoad, qntValue,
        input  intSig, pcEnable, running, qntCount
    );

    modport slave (
        input  stopQnt, rstQnt, halt, ioDone, qntLoad, qntValue,
        output intSig, pcEnable, running, qntCount
    );
endinterface

// File: rtl/quantum_scheduler.sv
// Preemption timer and fetch gating: counts cycles of the running process
// against a programmable quantum, raises a one-cycle intSig on expiry and
// freezes the PC while an input Halt is outstanding.
module quantum_scheduler #(
    parameter int QNT_WIDTH   = 16,
    parameter int DEFAULT_QNT = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    quantum_scheduler_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t               state_q, state_d;
    state_t               ret_q, ret_d;
    state_t               after_ctl;
    logic                 pend_q, pend_d;
    logic                 int_q, int_d;
    logic                 pcen_q, pcen_d;
    logic                 fire;
    logic                 due;
    logic [QNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [QNT_WIDTH-1:0] qnt_q;
    logic [QNT_WIDTH:0]   cnt_inc;

    // One extra bit so a quantum reloaded below the current count still
    // expires on the next counting edge instead of wrapping.
    assign cnt_inc = {1'b0, cnt_q} + (QNT_WIDTH+1)'(1);
    assign due     = (state_q == ST_RUN) && (cnt_inc >= {1'b0, qnt_q});

    // Next-state, counter and output decode.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        pcen_d    = pcen_q;
        int_d     = 1'b0;
        fire      = 1'b0;
        after_ctl = state_q;
        if (state_q == ST_WAIT) begin
            if (bus.ioDone) begin
                pcen_d = 1'b1;
                pend_d = 1'b0;
                if (pend_q) begin
                    int_d   = 1'b1;
                    state_d = ST_STOPPED;
                end else begin
                    state_d = ret_q;
                end
            end
        end else begin
            // Resolve stop/dispatch/expiry first, then decide whether the
            // halt redirects that outcome into WAIT as the return state.
            if (bus.stopQnt) begin
                after_ctl = ST_STOPPED;
                if (bus.rstQnt || due) cnt_d = '0;
            end else if (bus.rstQnt) begin
                after_ctl = ST_RUN;
                cnt_d     = '0;
            end else if (due) begin
                after_ctl = ST_STOPPED;
                cnt_d     = '0;
                fire      = 1'b1;
            end else if (state_q == ST_RUN && !bus.halt) begin
                cnt_d = cnt_inc[QNT_WIDTH-1:0];
            end
            if (bus.halt) begin
                state_d = ST_WAIT;
                ret_d   = after_ctl;
                pend_d  = fire;
                pcen_d  = 1'b0;
            end else begin
                state_d = after_ctl;
                int_d   = fire;
            end
        end
    end

    // Control state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOPPED;
            ret_q   <= ST_STOPPED;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            int_q   <= 1'b0;
            pcen_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            pcen_q  <= pcen_d;
        end
    end

    // Quantum register; a zero load is rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qnt_q <= QNT_WIDTH'(DEFAULT_QNT);
        end else if (bus.qntLoad && bus.qntValue != '0) begin
            qnt_q <= bus.qntValue;
        end
    end

    assign bus.intSig   = int_q;
    assign bus.pcEnable = pcen_q;
    assign bus.running  = (state_q == ST_RUN);
    assign bus.qntCount = cnt_q;

endmodule
